// File: rtl/spi_master_if.sv
`default_nettype none
// spi_master_if: host request/response signals plus SPI pins for spi_master.
// Revision: 1.0
interface spi_master_if;
   logic       start;
   logic [1:0] rsel;
   logic [7:0] wdata;
   logic       miso;
   logic       sclk;
   logic       mosi;
   logic [3:0] ss_n;
   logic [7:0] rdata;
   logic       busy;
   logic       done;

   modport master (
      input  start, rsel, wdata, miso,
      output sclk, mosi, ss_n, rdata, busy, done
   );

   modport slave (
      output start, rsel, wdata, miso,
      input  sclk, mosi, ss_n, rdata, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// spi_master: mode-0 SPI byte master with four active-low selects, registered outputs.
// Revision: 1.0
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   spi_master_if.master   bus
);

   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t     r_state, w_state_nx;
   logic [7:0] r_div_cnt, w_div_nx;
   logic [2:0] r_bit_cnt, w_bit_nx;
   logic [7:0] r_tx, w_tx_nx;
   logic [7:0] r_rx_sr, w_rx_nx;
   logic [7:0] r_rdata, w_rdata_nx;
   logic [3:0] r_ss_n, w_ss_nx;
   logic       r_sclk, w_sclk_nx;
   logic       r_mosi, w_mosi_nx;
   logic       r_busy, w_busy_nx;
   logic       r_done, w_done_nx;
   logic       r_armed;
   logic       w_div_last;

   assign w_div_last = (r_div_cnt == c_DIV_LAST);

   // r_armed blocks START on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_div_cnt <= 8'd0;
         r_bit_cnt <= 3'd0;
         r_tx      <= 8'd0;
         r_rx_sr   <= 8'd0;
         r_rdata   <= 8'd0;
         r_ss_n    <= 4'b1111;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_div_cnt <= w_div_nx;
         r_bit_cnt <= w_bit_nx;
         r_tx      <= w_tx_nx;
         r_rx_sr   <= w_rx_nx;
         r_rdata   <= w_rdata_nx;
         r_ss_n    <= w_ss_nx;
         r_sclk    <= w_sclk_nx;
         r_mosi    <= w_mosi_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
         r_armed   <= 1'b1;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_div_nx   = r_div_cnt;
      w_bit_nx   = r_bit_cnt;
      w_tx_nx    = r_tx;
      w_rx_nx    = r_rx_sr;
      w_rdata_nx = r_rdata;
      w_ss_nx    = r_ss_n;
      w_sclk_nx  = r_sclk;
      w_mosi_nx  = r_mosi;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_sclk_nx = 1'b0;
            w_mosi_nx = 1'b0;
            w_ss_nx   = 4'b1111;
            w_busy_nx = 1'b0;
            if (bus.start && r_armed) begin
               w_state_nx = SETUP;
               w_busy_nx  = 1'b1;
               w_ss_nx    = ~(4'b0001 << bus.rsel);
               w_tx_nx    = bus.wdata;
               w_mosi_nx  = bus.wdata[7];
               w_div_nx   = 8'd0;
               w_bit_nx   = 3'd0;
               w_rx_nx    = 8'd0;
            end
         end

         SETUP: begin
            if (w_div_last) begin
               w_div_nx   = 8'd0;
               w_state_nx = SHIFT;
               w_sclk_nx  = 1'b1;
               w_rx_nx    = {r_rx_sr[6:0], bus.miso};
            end else begin
               w_div_nx = r_div_cnt + 8'd1;
            end
         end

         SHIFT: begin
            if (!w_div_last) begin
               w_div_nx = r_div_cnt + 8'd1;
            end else if (r_sclk) begin
               // Falling SCLK: present the next lower bit, except after bit 0.
               w_div_nx  = 8'd0;
               w_sclk_nx = 1'b0;
               if (r_bit_cnt != 3'd7) begin
                  w_mosi_nx = r_tx[3'd6 - r_bit_cnt];
               end
            end else if (r_bit_cnt == 3'd7) begin
               w_div_nx   = 8'd0;
               w_state_nx = HOLD;
            end else begin
               w_div_nx  = 8'd0;
               w_bit_nx  = r_bit_cnt + 3'd1;
               w_sclk_nx = 1'b1;
               w_rx_nx   = {r_rx_sr[6:0], bus.miso};
            end
         end

         HOLD: begin
            if (w_div_last) begin
               w_div_nx   = 8'd0;
               w_bit_nx   = 3'd0;
               w_state_nx = IDLE;
               w_busy_nx  = 1'b0;
               w_ss_nx    = 4'b1111;
               w_mosi_nx  = 1'b0;
               w_done_nx  = 1'b1;
               w_rdata_nx = r_rx_sr;
            end else begin
               w_div_nx = r_div_cnt + 8'd1;
            end
         end

         default: w_state_nx = IDLE;
      endcase
   end

   assign bus.sclk  = r_sclk;
   assign bus.mosi  = r_mosi;
   assign bus.ss_n  = r_ss_n;
   assign bus.rdata = r_rdata;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// tb_spi_master: random and directed stimulus on CLK_DIV=4 and CLK_DIV=1 masters,
// checked every cycle against a timeline model of one transfer.
module tb_spi_master;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   spi_master_if b4 ();
   spi_master_if b1 ();

   spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.master));
   spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

   int checks   = 0;
   int failures = 0;

   // miso source per instance: 0 = tied low, 1 = loopback from mosi, 2 = random
   int   mode_v [2];
   logic rnd_v  [2];

   assign b4.miso = (mode_v[0] == 1) ? b4.mosi : ((mode_v[0] == 2) ? rnd_v[0] : 1'b0);
   assign b1.miso = (mode_v[1] == 1) ? b1.mosi : ((mode_v[1] == 2) ? rnd_v[1] : 1'b0);

   logic       sclk_v [2], mosi_v [2], busy_v [2], done_v [2], miso_v [2], start_v [2];
   logic [3:0] ss_v   [2];
   logic [7:0] rd_v   [2], wd_v [2];
   logic [1:0] rs_v   [2];

   always_comb begin
      sclk_v[0] = b4.sclk;   sclk_v[1] = b1.sclk;
      mosi_v[0] = b4.mosi;   mosi_v[1] = b1.mosi;
      busy_v[0] = b4.busy;   busy_v[1] = b1.busy;
      done_v[0] = b4.done;   done_v[1] = b1.done;
      miso_v[0] = b4.miso;   miso_v[1] = b1.miso;
      start_v[0] = b4.start; start_v[1] = b1.start;
      ss_v[0]   = b4.ss_n;   ss_v[1]   = b1.ss_n;
      rd_v[0]   = b4.rdata;  rd_v[1]   = b1.rdata;
      wd_v[0]   = b4.wdata;  wd_v[1]   = b1.wdata;
      rs_v[0]   = b4.rsel;   rs_v[1]   = b1.rsel;
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input int i, input logic st, input logic [1:0] rs, input logic [7:0] w);
      if (i == 0) begin
         b4.start = st; b4.rsel = rs; b4.wdata = w;
      end else begin
         b1.start = st; b1.rsel = rs; b1.wdata = w;
      end
   endtask

   initial begin
      rnd_v[0] = 1'b0;
      rnd_v[1] = 1'b0;
      forever begin
         @(posedge clk); #2;
         rnd_v[0] = 1'($urandom);
         rnd_v[1] = 1'($urandom);
      end
   end

   // Timeline model: t counts cycles since the accepting edge. Busy spans
   // t < 18d; SCLK is high for d cycles starting at t = d + 2kd; MOSI shows
   // bit 7-min(7, t/2d); MISO is sampled just before each rising edge.
   bit         act_m  [2];
   int         t_m    [2];
   logic [7:0] w_m    [2], rx_m [2], rexp_m [2];
   logic [1:0] rs_m   [2];
   int         edges = 0;

   always @(negedge clk) begin
      int d, idx, tt;
      logic e_sc, e_mo, e_bz, e_dn;
      logic [3:0] e_ss;
      for (int i = 0; i < 2; i++) begin
         d = (i == 0) ? 4 : 1;
         if (!rst_n) begin
            act_m[i]  = 1'b0;
            rexp_m[i] = 8'h00;
         end
         e_sc = 1'b0; e_mo = 1'b0; e_bz = 1'b0; e_dn = 1'b0; e_ss = 4'hF;
         if (act_m[i]) begin
            tt   = t_m[i];
            e_bz = (tt < 18 * d);
            e_dn = (tt == 18 * d);
            if (e_bz) begin
               e_ss = ~(4'b0001 << rs_m[i]);
               idx  = tt / (2 * d);
               if (idx > 7) idx = 7;
               e_mo = w_m[i][7 - idx];
               e_sc = (tt >= d) && (tt < 17 * d) && (((tt - d) % (2 * d)) < d);
            end
         end
         check($sformatf("div%0d sclk", d),  32'(sclk_v[i]), 32'(e_sc));
         check($sformatf("div%0d mosi", d),  32'(mosi_v[i]), 32'(e_mo));
         check($sformatf("div%0d busy", d),  32'(busy_v[i]), 32'(e_bz));
         check($sformatf("div%0d done", d),  32'(done_v[i]), 32'(e_dn));
         check($sformatf("div%0d ss_n", d),  32'(ss_v[i]),   32'(e_ss));
         check($sformatf("div%0d rdata", d), 32'(rd_v[i]),   32'(rexp_m[i]));
         if (rst_n) begin
            if (act_m[i] && t_m[i] < 18 * d) begin
               tt = t_m[i] + 1;
               if (tt >= d && tt <= 15 * d && ((tt - d) % (2 * d)) == 0)
                  rx_m[i] = {rx_m[i][6:0], miso_v[i]};
               t_m[i] = tt;
               if (tt == 18 * d) rexp_m[i] = rx_m[i];
            end else if (start_v[i] && edges >= 1) begin
               act_m[i] = 1'b1;
               t_m[i]   = 0;
               w_m[i]   = wd_v[i];
               rs_m[i]  = rs_v[i];
               rx_m[i]  = 8'h00;
            end else begin
               act_m[i] = 1'b0;
            end
         end
      end
      if (!rst_n) edges = 0;
      else        edges++;
   end

   task automatic wait_done(input int i);
      bit seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done_v[i]) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_done", 32'(seen), 32'd1);
   endtask

   task automatic run_xfer(input int i, input logic [7:0] w, input logic [1:0] rs,
                           input int mode, input bit poke,
                           output int bc, output logic [7:0] mo, output int rises,
                           output int hc, output int dn, output logic [3:0] ssn);
      logic prev;
      int   post;
      int   d;
      d = (i == 0) ? 4 : 1;
      bc = 0; mo = 8'h00; rises = 0; hc = 0; dn = 0; ssn = 4'hF; prev = 1'b0; post = 0;
      mode_v[i] = mode;
      @(posedge clk); #2;
      drive(i, 1'b1, rs, w);
      @(posedge clk); #2;
      drive(i, 1'b0, 2'($urandom), 8'($urandom));
      for (int c = 0; c < 40 * d + 100; c++) begin
         @(negedge clk);
         if (busy_v[i]) begin
            bc++;
            ssn = ss_v[i];
         end
         if (sclk_v[i]) hc++;
         if (sclk_v[i] && !prev) begin
            rises++;
            mo = {mo[6:0], mosi_v[i]};
         end
         prev = sclk_v[i];
         if (done_v[i]) dn++;
         if (dn > 0) post++;
         if (post > 5) break;
         @(posedge clk); #2;
         if (poke && c == 10) drive(i, 1'b1, 2'd3, 8'hFF);
         else                 drive(i, 1'b0, 2'($urandom), 8'($urandom));
      end
   endtask

   initial begin
      int         bc, rises, hc, dn, gap;
      logic [7:0] mo;
      logic [3:0] ssn, ss1, ss2;
      bit         s2;
      logic       prev;

      mode_v[0] = 0;
      mode_v[1] = 0;
      drive(0, 1'b0, 2'd0, 8'h00);
      drive(1, 1'b0, 2'd0, 8'h00);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset ss_n",  32'(b4.ss_n),  32'hF);
      check("reset busy",  32'(b4.busy),  32'd0);
      check("reset sclk",  32'(b4.sclk),  32'd0);
      check("reset mosi",  32'(b4.mosi),  32'd0);
      check("reset rdata", 32'(b4.rdata), 32'h00);
      check("reset done",  32'(b4.done),  32'd0);

      // START already high when reset releases: first edge ignores it.
      drive(0, 1'b1, 2'd1, 8'h11);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      check("start ignored on release edge", 32'(b4.busy), 32'd0);
      @(posedge clk); #2;
      check("start taken next edge", 32'(b4.busy), 32'd1);
      drive(0, 1'b0, 2'd0, 8'h00);
      wait_done(0);

      run_xfer(0, 8'hA5, 2'd2, 0, 1'b0, bc, mo, rises, hc, dn, ssn);
      check("A5 busy cycles", 32'(bc), 32'd72);
      check("A5 mosi bits",   32'(mo), 32'hA5);
      check("A5 sclk rises",  32'(rises), 32'd8);
      check("A5 sclk high",   32'(hc), 32'd32);
      check("A5 ss_n",        32'(ssn), 32'hB);
      check("A5 done count",  32'(dn), 32'd1);
      check("A5 rdata",       32'(b4.rdata), 32'h00);

      run_xfer(0, 8'h3C, 2'd0, 1, 1'b0, bc, mo, rises, hc, dn, ssn);
      check("loop 3C rdata", 32'(b4.rdata), 32'h3C);
      check("loop 3C ss_n",  32'(ssn), 32'hE);

      run_xfer(0, 8'h81, 2'd3, 2, 1'b1, bc, mo, rises, hc, dn, ssn);
      check("reject mosi bits",  32'(mo), 32'h81);
      check("reject done count", 32'(dn), 32'd1);

      // Back-to-back: START held across the DONE cycle.
      mode_v[0] = 1;
      @(posedge clk); #2;
      drive(0, 1'b1, 2'd1, 8'h96);
      dn = 0; gap = 0; s2 = 1'b0; ss1 = 4'hF; ss2 = 4'hF;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (busy_v[0]) begin
            if (dn == 0) ss1 = ss_v[0];
            else begin
               ss2 = ss_v[0];
               s2  = 1'b1;
            end
         end
         if (done_v[0]) dn++;
         if (ss_v[0] == 4'hF && dn == 1 && !s2) gap++;
         if (dn == 2) break;
         @(posedge clk); #2;
         if (s2)          drive(0, 1'b0, 2'd0, 8'h00);
         else if (c == 5) drive(0, 1'b1, 2'd3, 8'h69);
      end
      check("b2b done count", 32'(dn), 32'd2);
      check("b2b ss_n gap",   32'(gap), 32'd1);
      check("b2b ss_n first", 32'(ss1), 32'hD);
      check("b2b ss_n second", 32'(ss2), 32'h7);
      check("b2b rdata",      32'(b4.rdata), 32'h69);

      // Reset after the third SCLK rise.
      mode_v[0] = 2;
      @(posedge clk); #2;
      drive(0, 1'b1, 2'd1, 8'hC3);
      @(posedge clk); #2;
      drive(0, 1'b0, 2'd0, 8'h00);
      rises = 0; prev = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (sclk_v[0] && !prev) rises++;
         prev = sclk_v[0];
         if (rises == 3) break;
      end
      check("abort rises seen", 32'(rises), 32'd3);
      check("abort rdata before", 32'(b4.rdata), 32'h69);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort ss_n",  32'(b4.ss_n),  32'hF);
      check("abort sclk",  32'(b4.sclk),  32'd0);
      check("abort busy",  32'(b4.busy),  32'd0);
      check("abort done",  32'(b4.done),  32'd0);
      check("abort rdata", 32'(b4.rdata), 32'h00);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      dn = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_v[0]) dn++;
      end
      check("abort no done", 32'(dn), 32'd0);

      run_xfer(1, 8'h5A, 2'd2, 1, 1'b0, bc, mo, rises, hc, dn, ssn);
      check("div1 busy cycles", 32'(bc), 32'd18);
      check("div1 rdata",       32'(b1.rdata), 32'h5A);
      check("div1 mosi bits",   32'(mo), 32'h5A);
      check("div1 sclk high",   32'(hc), 32'd8);

      for (int n = 0; n < 24; n++) begin
         run_xfer(n % 2, 8'($urandom), 2'($urandom), 1 + int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), bc, mo, rises, hc, dn, ssn);
         check("random done count", 32'(dn), 32'd1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
